// File: rtl/rf_pkg.sv
// Shared constants for the 8 x 8-bit register file and its write-back path.
// R0 is the hardwired-zero register; writes to it are discarded.
package rf_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int NREGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] R0 = '0;
endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, rotation pointer
// moves to the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic          found;
  int            idx;

  // search starts just past the last winner
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gidx = PW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PW'(N - 1);
    end else if (advance && found) begin
      ptr <= gidx;
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter + pending-destination scoreboard for the register file.
// Optional forwarding from the output register: define RF_WB_BYPASS_EN.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          wb_req,
  input  logic [NREQ*ADDR_W-1:0]   wb_addr,
  input  logic [NREQ*DATA_W-1:0]   wb_data,
  output logic [NREQ-1:0]          wb_gnt,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_rd,
  input  logic [ADDR_W-1:0]        chk_a,
  input  logic [ADDR_W-1:0]        chk_b,
  output logic                     hazard_a,
  output logic                     hazard_b,
  output logic                     rf_write,
  output logic [ADDR_W-1:0]        rf_da,
  output logic [DATA_W-1:0]        rf_din,
`ifdef RF_WB_BYPASS_EN
  output logic                     byp_a_valid,
  output logic                     byp_b_valid,
  output logic [DATA_W-1:0]        byp_a_data,
  output logic [DATA_W-1:0]        byp_b_data,
`endif
  output logic [(1<<ADDR_W)-1:0]   busy
);
  import rf_pkg::*;

  localparam int NR = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = '0;

  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NR-1:0]     busy_nxt;
  logic              match_a;
  logic              match_b;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (wb_req),
    .advance (xfer),
    .gnt     (wb_gnt)
  );

  assign xfer = |(wb_req & wb_gnt);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (wb_gnt[i]) begin
        sel_addr = wb_addr[i*ADDR_W +: ADDR_W];
        sel_data = wb_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_write <= 1'b0;
      rf_da <= '0;
      rf_din <= '0;
    end else if (xfer) begin
      rf_write <= (sel_addr != ZA);
      rf_da <= sel_addr;
      rf_din <= sel_data;
    end else begin
      rf_write <= 1'b0;
    end
  end

  // a new reservation overrides a retiring write to the same register
  always_comb begin
    busy_nxt = busy;
    if (xfer && sel_addr != ZA) busy_nxt[sel_addr] = 1'b0;
    if (iss_valid && iss_rd != ZA) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  assign match_a = rf_write && (rf_da == chk_a) && (chk_a != ZA);
  assign match_b = rf_write && (rf_da == chk_b) && (chk_b != ZA);

`ifdef RF_WB_BYPASS_EN
  assign byp_a_valid = match_a;
  assign byp_b_valid = match_b;
  assign byp_a_data = rf_din;
  assign byp_b_data = rf_din;
  assign hazard_a = (chk_a != ZA) && busy[chk_a];
  assign hazard_b = (chk_b != ZA) && busy[chk_b];
`else
  assign hazard_a = (chk_a != ZA) && (busy[chk_a] || match_a);
  assign hazard_b = (chk_b != ZA) && (busy[chk_b] || match_b);
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed steps then random traffic
// against a behavioural model of grants, scoreboard and write port.
module tb_rf_wb_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] wb_req = '0;
  logic [N*3-1:0] wb_addr;
  logic [N*8-1:0] wb_data;
  logic [N-1:0] wb_gnt;
  logic iss_valid = 1'b0;
  logic [2:0] iss_rd = '0;
  logic [2:0] chk_a = '0;
  logic [2:0] chk_b = '0;
  logic hazard_a, hazard_b, rf_write;
  logic [2:0] rf_da;
  logic [7:0] rf_din;
  logic [7:0] busy;
`ifdef RF_WB_BYPASS_EN
  logic byp_a_valid, byp_b_valid;
  logic [7:0] byp_a_data, byp_b_data;
`endif

  logic [2:0] a_r [N];
  logic [7:0] d_r [N];

  int total = 0;
  int bad = 0;

  int m_ptr;
  bit [7:0] m_busy;
  bit m_wr;
  bit [2:0] m_da;
  bit [7:0] m_din;
  bit [N-1:0] pend;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      wb_addr[i*3 +: 3] = a_r[i];
      wb_data[i*8 +: 8] = d_r[i];
    end
  end

  rf_wb_arbiter #(.NREQ(N), .DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_gnt(wb_gnt),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_a(chk_a), .chk_b(chk_b),
    .hazard_a(hazard_a), .hazard_b(hazard_b),
    .rf_write(rf_write), .rf_da(rf_da), .rf_din(rf_din),
`ifdef RF_WB_BYPASS_EN
    .byp_a_valid(byp_a_valid), .byp_b_valid(byp_b_valid),
    .byp_a_data(byp_a_data), .byp_b_data(byp_b_data),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int win(input bit [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic bit [N-1:0] m_gnt(input bit [N-1:0] r);
    int w;
    w = win(r);
    return (w < 0) ? '0 : (N'(1) << w);
  endfunction

  function automatic bit m_haz(input bit [2:0] c);
    if (c == 0) return 1'b0;
`ifdef RF_WB_BYPASS_EN
    return m_busy[c];
`else
    return m_busy[c] || (m_wr && m_da == c);
`endif
  endfunction

  task automatic m_reset();
    m_ptr = N - 1;
    m_busy = '0;
    m_wr = 1'b0;
    m_da = '0;
    m_din = '0;
  endtask

  task automatic check_all();
    chk("gnt", 32'(wb_gnt), 32'(m_gnt(wb_req)));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("rf_write", 32'(rf_write), 32'(m_wr));
    chk("rf_da", 32'(rf_da), 32'(m_da));
    chk("rf_din", 32'(rf_din), 32'(m_din));
    chk("hazard_a", 32'(hazard_a), 32'(m_haz(chk_a)));
    chk("hazard_b", 32'(hazard_b), 32'(m_haz(chk_b)));
`ifdef RF_WB_BYPASS_EN
    chk("byp_a_valid", 32'(byp_a_valid),
        32'(m_wr && m_da == chk_a && chk_a != 0));
    chk("byp_b_valid", 32'(byp_b_valid),
        32'(m_wr && m_da == chk_b && chk_b != 0));
    if (byp_a_valid) chk("byp_a_data", 32'(byp_a_data), 32'(m_din));
`endif
  endtask

  // model of one clock edge, from the current inputs
  task automatic m_edge();
    int w;
    w = win(wb_req);
    if (w >= 0) begin
      m_ptr = w;
      m_wr = (a_r[w] != 0);
      m_da = a_r[w];
      m_din = d_r[w];
      if (a_r[w] != 0) m_busy[a_r[w]] = 1'b0;
    end else begin
      m_wr = 1'b0;
    end
    if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  // inputs set at negedge before calling; check then advance model
  task automatic cyc();
    #1;
    check_all();
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wb_req = '0;
    iss_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      a_r[i] = '0;
      d_r[i] = '0;
    end
    m_reset();
    @(negedge clk);
    #1;
    check_all();
    rst = 1'b0;
    @(negedge clk);

    // strict rotation under continuous request
    for (int i = 0; i < N; i++) begin
      a_r[i] = 3'(i + 1);
      d_r[i] = 8'(8'h11 * (i + 1));
    end
    wb_req = '1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rot", 32'(wb_gnt), 32'(1 << (c % 3)));
      cyc();
    end
    idle();
    cyc();

    // reserve r5, requester 1 retires it
    iss_valid = 1'b1;
    iss_rd = 3'd5;
    cyc();
    iss_valid = 1'b0;
    chk_a = 3'd5;
    a_r[1] = 3'd5;
    d_r[1] = 8'hA5;
    wb_req = 3'b010;
    cyc();
    wb_req = '0;
    chk("a5_da", 32'(rf_da), 32'd5);
    chk("a5_din", 32'(rf_din), 32'hA5);
    chk("a5_busy", 32'(busy[5]), 32'd0);
    cyc();

    // RAW on r3: hazard through the write cycle
    iss_valid = 1'b1;
    iss_rd = 3'd3;
    cyc();
    iss_valid = 1'b0;
    chk_a = 3'd3;
    cyc();
    a_r[2] = 3'd3;
    d_r[2] = 8'h3C;
    wb_req = 3'b100;
    cyc();
    wb_req = '0;
    cyc();
    cyc();

    // same-edge reserve and retire of r4
    iss_valid = 1'b1;
    iss_rd = 3'd4;
    cyc();
    a_r[0] = 3'd4;
    wb_req = 3'b001;
    cyc();
    idle();
    chk("r4_busy", 32'(busy[4]), 32'd1);
    cyc();

    // write to r0 is granted and dropped
    a_r[1] = 3'd0;
    d_r[1] = 8'hFF;
    wb_req = 3'b010;
    chk_a = 3'd0;
    cyc();
    wb_req = '0;
    chk("r0_wr", 32'(rf_write), 32'd0);
    cyc();

    // reset mid-operation
    iss_valid = 1'b1;
    iss_rd = 3'd1;
    cyc();
    iss_rd = 3'd2;
    cyc();
    iss_rd = 3'd3;
    a_r[0] = 3'd4;
    d_r[0] = 8'h44;
    wb_req = 3'b001;
    cyc();
    idle();
    #1;
    chk("pre_rst_wr", 32'(rf_write), 32'd1);
    rst = 1'b1;
    #1;
    m_reset();
    check_all();
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wb_req = '1;
    #1;
    chk("rst_first", 32'(wb_gnt), 32'd1);
    cyc();

    // random traffic with hold-until-granted requesters
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      bit [N-1:0] g;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          pend[i] = 1'b1;
          a_r[i] = 3'($urandom_range(0, 7));
          d_r[i] = 8'($urandom);
        end
      end
      wb_req = pend;
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd = 3'($urandom_range(0, 7));
      chk_a = 3'($urandom_range(0, 7));
      chk_b = 3'($urandom_range(0, 7));
      g = m_gnt(pend);
      cyc();
      pend = pend & ~g;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 8 x 8-bit register file. Shares the register file's single write port (write / Da / Din) among NREQ write-back requesters with round-robin priority. Tracks pending destination registers so the decode stage can detect read-after-write hazards on the two read ports. Sits between the execution units and the register file; drives the write port through one output register stage.

## Interface
- NREQ, 3, number of write-back requesters (2..4)
- DATA_W, 8, register data width
- ADDR_W, 3, register address width (2^ADDR_W registers; r0 is constant)
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- wb_req  in  NREQ  requester i wants to write
- wb_addr  in  NREQ*ADDR_W  destination of requester i (slice i)
- wb_data  in  NREQ*DATA_W  data of requester i (slice i)
- wb_gnt  out  NREQ  one-hot grant, combinational
- iss_valid  in  1  an instruction issues this cycle with destination iss_rd
- iss_rd  in  ADDR_W  destination register being reserved
- chk_a, chk_b  in  ADDR_W  read addresses presented to the register file
- hazard_a, hazard_b  out  1  read at chk_x must stall
- rf_write  out  1  to register file write
- rf_da  out  ADDR_W  to register file Da
- rf_din  out  DATA_W  to register file Din
- busy  out  2^ADDR_W  scoreboard bits (debug/visibility)

## Operation
- Arbitration: wb_gnt[i] = 1 for the first requesting i starting at (ptr+1) mod NREQ; at most one bit set; all zero when wb_req == 0.
- Transfer occurs at a posedge with wb_req[i] & wb_gnt[i]. Requester holds req/addr/data stable until granted; it drops req the cycle after a transfer or presents its next write.
- On transfer: ptr <= i; output register loads rf_da <= wb_addr[i], rf_din <= wb_data[i], rf_write <= (wb_addr[i] != 0). Transfer to r0 is granted and discarded (rf_write stays 0).
- No transfer: rf_write <= 0; rf_da/rf_din hold.
- Scoreboard: on transfer to addr d != 0, busy[d] <= 0. On iss_valid with iss_rd != 0, busy[iss_rd] <= 1. Same edge, same register, set and clear: set wins (newer reservation). busy[0] is always 0.
- Hazard (macro absent): hazard_x = busy[chk_x] | (rf_write & rf_da == chk_x); forced 0 when chk_x == 0.
- Granting is independent of busy; the scoreboard never blocks write-back.

## Timing
- Reset values: ptr = NREQ-1 (requester 0 highest after reset), busy = 0, rf_write = 0, rf_da = 0, rf_din = 0; hazard_a/b = 0.
- Grant: combinational, same cycle as request.
- Register file update: 2 edges after the request is sampled: edge 1 loads the output register, edge 2 writes the register file.
- busy clears at edge 1; hazard stays asserted through the rf_write cycle through the rf_da match term, so reads see the new value from the cycle after edge 2.
- Reset asserted mid-operation: pending output-register write is dropped, busy is cleared, no register file write occurs.
- Throughput: one write per cycle; a continuously requesting set of N requesters receives grants in strict rotation.

## Configuration
- RF_WB_BYPASS_EN defined: adds outputs byp_a_valid, byp_b_valid (1 bit) and byp_a_data, byp_b_data (DATA_W). byp_x_valid = rf_write & rf_da == chk_x & chk_x != 0; byp_x_data = rf_din. hazard_x = busy[chk_x] only, which saves one stall cycle per dependent read.
- Undefined: bypass ports absent; hazard includes the rf_write match term as above.

## Structure
- Shared package rf_pkg: DATA_W, ADDR_W, NREGS = 2^ADDR_W, R0 = 0 constant.
- One sub-module, rr_arbiter: parameter N; inputs clk, rst, req, advance; output one-hot gnt; holds the rotation pointer. The top level handles the scoreboard, the output register and the hazard/bypass logic.

## Test plan
- Reset then wb_req=3'b111, all held -> grants 0,1,2,0,1,2 on consecutive cycles; rf_write high from cycle 2.
- Requester 1 writes addr 5, data 8'hA5 -> rf_write=1, rf_da=5, rf_din=A5 the next cycle; busy[5] clears at the transfer edge.
- iss_valid, iss_rd=3, then chk_a=3 -> hazard_a=1 until the rf_write cycle for r3 ends (with RF_WB_BYPASS_EN: byp_a_valid=1, byp_a_data correct, hazard_a=0 in that cycle).
- Same-edge iss_rd=4 and transfer to addr 4 -> busy[4]=1 afterwards.
- Write to addr 0 with data 8'hFF -> wb_gnt asserted, rf_write stays 0, busy unchanged; chk_a=0 -> hazard_a=0.
- Assert rst while rf_write=1 and busy=8'h0E -> all outputs return to 0 immediately; after release, requester 0 wins first.
